// File: rtl/piso_frame_tx.sv
// piso_frame_tx: parallel-in / serial-out frame transmitter.
//
// Takes a WIDTH-bit word over a valid/ready handshake and shifts it out on
// SO, MSB first, one bit per CP period. Every state update happens on the
// falling edge of CP, so a SIPO register clocked on the same edge can take
// SO directly as its serial input.
//
// Ports:
//   CP          clock; state updates on the falling edge
//   clr         synchronous active-high reset, sampled on the falling edge
//   PI          parallel word to transmit
//   load_valid  PI is valid and requests transmission
//   load_ready  transmitter can accept a word (IDLE)
//   hold        pause shifting; the current bit stays on SO
//   SO          serial data out, MSB first; IDLE_LEVEL between frames
//   so_valid    SO carries a frame bit this cycle
//   frame_start high while SO carries the first bit (bit WIDTH-1)
//   done        one-cycle pulse in the first IDLE cycle after a frame
//   busy        high while a frame is being shifted
module piso_frame_tx #(
    parameter int WIDTH      = 4,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             CP,
    input  logic             clr,
    input  logic [WIDTH-1:0] PI,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             hold,
    output logic             SO,
    output logic             so_valid,
    output logic             frame_start,
    output logic             done,
    output logic             busy
);

    localparam int              CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   shreg, shreg_nxt;
    logic [CW-1:0]      bit_cnt, cnt_nxt;
    logic               done_nxt;

    always_ff @(negedge CP) begin
        if (clr) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            bit_cnt <= cnt_nxt;
            done    <= done_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        cnt_nxt     = bit_cnt;
        done_nxt    = 1'b0;
        load_ready  = 1'b0;
        busy        = 1'b0;
        so_valid    = 1'b0;
        frame_start = 1'b0;
        SO          = IDLE_LEVEL;
        unique case (state)
            IDLE: begin
                // The done cycle is already IDLE, so a waiting word is taken
                // here and frames run with a single idle cycle between them.
                load_ready = 1'b1;
                if (load_valid) begin
                    state_nxt = SHIFT;
                    shreg_nxt = PI;
                    cnt_nxt   = '0;
                end
            end
            SHIFT: begin
                busy        = 1'b1;
                so_valid    = 1'b1;
                SO          = shreg[WIDTH-1];
                frame_start = (bit_cnt == '0);
                if (!hold) begin
                    shreg_nxt = {shreg[WIDTH-2:0], 1'b0};
                    if (bit_cnt == LAST) begin
                        // Last bit has had its full cycle; counter is parked
                        // at zero rather than allowed to step past WIDTH-1.
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                        done_nxt  = 1'b1;
                    end else begin
                        cnt_nxt = bit_cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_piso_frame_tx.sv
// Testbench for piso_frame_tx: directed test-plan steps followed by random
// traffic, all checked against a queue-based model of the frame in flight.
// A small receiving SIPO (shifting only on real, non-held frame bits) is
// checked against the accepted word whenever done is high.
module tb_piso_frame_tx;
    localparam int W  = 4;
    localparam bit IL = 1'b0;

    logic         CP = 1'b1;
    logic         clr, load_valid, hold;
    logic [W-1:0] PI;
    logic         load_ready, SO, so_valid, frame_start, done, busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic         q[$];       // bits still to be shown on SO, front = current
    logic         exp_done;
    logic [W-1:0] last_word;
    logic [W-1:0] sipo;

    piso_frame_tx #(.WIDTH(W), .IDLE_LEVEL(IL)) dut (
        .CP(CP), .clr(clr), .PI(PI), .load_valid(load_valid),
        .load_ready(load_ready), .hold(hold), .SO(SO), .so_valid(so_valid),
        .frame_start(frame_start), .done(done), .busy(busy)
    );

    always #5 CP = ~CP;

    always @(negedge CP)
        if (so_valid && !hold) sipo <= {sipo[W-2:0], SO};

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Drive inputs, let one falling edge take them, update the model, then
    // compare outputs on the following rising edge.
    task automatic tick(input logic [W-1:0] pv, input logic lv, input logic hd, input logic rs);
        logic nd;
        logic cur;
        PI = pv; load_valid = lv; hold = hd; clr = rs;
        @(negedge CP);
        nd = 1'b0;
        if (rs) begin
            q.delete();
        end else if (q.size() != 0) begin
            if (!hd) begin
                void'(q.pop_front());
                if (q.size() == 0) nd = 1'b1;
            end
        end else if (lv) begin
            last_word = pv;
            for (int i = W - 1; i >= 0; i--) q.push_back(pv[i]);
        end
        exp_done = nd;
        @(posedge CP);
        cyc++;
        cur = (q.size() != 0);
        chk("so_valid",    16'(so_valid),    16'(cur));
        chk("busy",        16'(busy),        16'(cur));
        chk("load_ready",  16'(load_ready),  16'(!cur));
        chk("SO",          16'(SO),          16'(cur ? q[0] : IL));
        chk("frame_start", 16'(frame_start), 16'(q.size() == W));
        chk("done",        16'(done),        16'(exp_done));
        if (exp_done) chk("loopback", 16'(sipo), 16'(last_word));
    endtask

    initial begin
        clr = 1'b1; load_valid = 1'b0; hold = 1'b0; PI = '0;
        exp_done = 1'b0; last_word = '0;

        // Reset with a competing load request: nothing may start.
        tick(4'b1010, 1'b1, 1'b0, 1'b1);
        tick(4'b1010, 1'b1, 1'b0, 1'b1);
        tick(4'b0000, 1'b0, 1'b0, 1'b0);

        // Single frame.
        tick(4'b1011, 1'b1, 1'b0, 1'b0);
        repeat (6) tick(4'b0000, 1'b0, 1'b0, 1'b0);

        // Back-to-back with load_valid held high.
        tick(4'b1100, 1'b1, 1'b0, 1'b0);
        repeat (5) tick(4'b0011, 1'b1, 1'b0, 1'b0);
        repeat (6) tick(4'b0000, 1'b0, 1'b0, 1'b0);

        // Hold for three cycles on the second bit.
        tick(4'b1001, 1'b1, 1'b0, 1'b0);
        tick(4'b0000, 1'b0, 1'b0, 1'b0);
        repeat (3) tick(4'b0000, 1'b0, 1'b1, 1'b0);
        repeat (5) tick(4'b0000, 1'b0, 1'b0, 1'b0);

        // Hold on the last bit, and hold while idle.
        tick(4'b0101, 1'b1, 1'b0, 1'b0);
        repeat (3) tick(4'b0000, 1'b0, 1'b0, 1'b0);
        repeat (2) tick(4'b0000, 1'b0, 1'b1, 1'b0);
        repeat (3) tick(4'b0000, 1'b0, 1'b0, 1'b0);
        repeat (2) tick(4'b0000, 1'b0, 1'b1, 1'b0);

        // Abort mid-frame, then a normal frame with loopback check.
        tick(4'b1111, 1'b1, 1'b0, 1'b0);
        tick(4'b0000, 1'b0, 1'b0, 1'b0);
        tick(4'b0000, 1'b0, 1'b0, 1'b1);
        repeat (2) tick(4'b0000, 1'b0, 1'b0, 1'b0);
        tick(4'b0110, 1'b1, 1'b0, 1'b0);
        repeat (6) tick(4'b0000, 1'b0, 1'b0, 1'b0);

        // Random traffic.
        for (int n = 0; n < 400; n++)
            tick(W'($urandom), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 40) == 0));
        repeat (8) tick(4'b0000, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
